// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame driver: pattern modes,
// colour-bar flags and the default 480x272 panel timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        EXTERNAL = 2'd0,
        SOLID    = 2'd1,
        BARS     = 2'd2,
        CHECKER  = 2'd3
    } mode_t;

    // Per-bar {R,G,B} full-scale flags, index 0 = leftmost bar; widened to COLOR_W by the user.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,  // black
        3'b001,  // blue
        3'b100,  // red
        3'b101,  // magenta
        3'b010,  // green
        3'b011,  // cyan
        3'b110,  // yellow
        3'b111   // white
    };

    localparam int unsigned DEF_H_ACTIVE = 480;
    localparam int unsigned DEF_H_FP     = 2;
    localparam int unsigned DEF_H_SYNC   = 41;
    localparam int unsigned DEF_H_BP     = 2;
    localparam int unsigned DEF_V_ACTIVE = 272;
    localparam int unsigned DEF_V_FP     = 2;
    localparam int unsigned DEF_V_SYNC   = 10;
    localparam int unsigned DEF_V_BP     = 2;

endpackage

// File: rtl/lcd_timing_counter.sv
// Raster position counters for the LCD panel plus combinational decode of
// sync, data-enable and frame-origin for the current (h,v) slot.
module lcd_timing_counter import lcd_pkg::*; #(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          de,
    output logic          hs_act,
    output logic          vs_act,
    output logic          origin
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (32'(h) == H_TOTAL - 1) begin
                h <= '0;
                v <= (32'(v) == V_TOTAL - 1) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    // Compares run at 32 bits so region bounds equal to 2^HW do not truncate.
    always_comb begin
        de     = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        hs_act = (32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
        vs_act = (32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
        origin = (h == '0) && (v == '0);
    end

endmodule

// File: rtl/lcd_frame_driver.sv
// Parallel-RGB LCD driver: pixel-clock divider, panel timing, pattern source
// and show-ahead pixel FIFO handshake driving the panel pins directly.
module lcd_frame_driver import lcd_pkg::*; #(
    parameter int unsigned CLOCK_DIV   = 2,
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned CHECK_SHIFT = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_color,
    input  logic [3*COLOR_W-1:0] pix_data,
    input  logic                 pix_empty,
    output logic                 pix_req,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 lcd_clk,
    output logic                 lcd_disp,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 lcd_de,
    output logic                 frame_start,
    output logic [15:0]          underflow_count
);

    localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned DW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [HW-1:0]        h;
    logic [VW-1:0]        v;
    logic                 de_now, hs_act, vs_act, origin;
    mode_t                mode_q, mode_eff;
    logic [2:0]           bar;
    logic [3*COLOR_W-1:0] pattern;
    logic [15:0]          uf_cnt;

    // Ticks on the falling-edge cycle so data is settled for the panel's rising-edge sample.
    assign tick = (32'(div_cnt) == CLOCK_DIV - 1) && lcd_clk;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            lcd_clk <= 1'b0;
        end else if (32'(div_cnt) == CLOCK_DIV - 1) begin
            div_cnt <= '0;
            lcd_clk <= ~lcd_clk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    lcd_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk    (CLOCK_50),
        .rst    (reset),
        .tick   (tick),
        .h      (h),
        .v      (v),
        .de     (de_now),
        .hs_act (hs_act),
        .vs_act (vs_act),
        .origin (origin)
    );

    // The origin pixel already uses the newly latched mode.
    assign mode_eff = origin ? mode_t'(mode) : mode_q;

    always_comb begin
        bar = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(h) * 32'd8 >= i * H_ACTIVE) bar = 3'(i);
        end
        pattern = '0;
        case (mode_eff)
            EXTERNAL: pattern = pix_empty ? solid_color : pix_data;
            SOLID:    pattern = solid_color;
            BARS:     pattern = {{COLOR_W{BAR_RGB[bar][2]}},
                                 {COLOR_W{BAR_RGB[bar][1]}},
                                 {COLOR_W{BAR_RGB[bar][0]}}};
            CHECKER:  pattern = 1'((32'(h) >> CHECK_SHIFT) ^ (32'(v) >> CHECK_SHIFT)) ? '0 : solid_color;
            default:  pattern = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            lcd_de      <= 1'b0;
            lcd_disp    <= 1'b0;
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            uf_cnt      <= '0;
            mode_q      <= SOLID;
        end else begin
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                {red, green, blue} <= de_now ? pattern : '0;
                hsync  <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync  <= vs_act ? SYNC_POL : ~SYNC_POL;
                lcd_de <= de_now;
                if (origin) begin
                    frame_start <= 1'b1;
                    lcd_disp    <= 1'b1;
                    mode_q      <= mode_eff;
                end
                if (de_now && mode_eff == EXTERNAL) begin
                    if (!pix_empty) pix_req <= 1'b1;
                    else if (uf_cnt != '1) uf_cnt <= uf_cnt + 16'd1;
                end
            end
        end
    end

    assign underflow_count = uf_cnt;

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Bench for lcd_frame_driver: small-raster instance against a raster-walking
// reference model, plus a full-size instance checked from a bar/checker table.
`timescale 1ns/1ps
module tb_lcd_frame_driver;

    localparam int unsigned CD = 2;
    localparam int unsigned HA = 8, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
    localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // small instance
    logic        reset_s, pix_empty_s, pix_req_s;
    logic [1:0]  mode_s;
    logic [23:0] solid_s, pix_data_s;
    logic [7:0]  red_s, green_s, blue_s;
    logic        lcd_clk_s, lcd_disp_s, hsync_s, vsync_s, lcd_de_s, fs_s;
    logic [15:0] uf_s;

    // full-size instance
    logic        reset_b, pix_empty_b, pix_req_b;
    logic [1:0]  mode_b;
    logic [23:0] solid_b, pix_data_b;
    logic [7:0]  red_b, green_b, blue_b;
    logic        lcd_clk_b, lcd_disp_b, hsync_b, vsync_b, lcd_de_b, fs_b;
    logic [15:0] uf_b;

    lcd_frame_driver #(
        .CLOCK_DIV (CD), .COLOR_W (8),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0), .CHECK_SHIFT (4)
    ) dut_s (
        .CLOCK_50 (CLOCK_50), .reset (reset_s), .mode (mode_s),
        .solid_color (solid_s), .pix_data (pix_data_s), .pix_empty (pix_empty_s),
        .pix_req (pix_req_s), .red (red_s), .green (green_s), .blue (blue_s),
        .lcd_clk (lcd_clk_s), .lcd_disp (lcd_disp_s), .hsync (hsync_s), .vsync (vsync_s),
        .lcd_de (lcd_de_s), .frame_start (fs_s), .underflow_count (uf_s)
    );

    lcd_frame_driver #(
        .CLOCK_DIV (2), .COLOR_W (8)
    ) dut_b (
        .CLOCK_50 (CLOCK_50), .reset (reset_b), .mode (mode_b),
        .solid_color (solid_b), .pix_data (pix_data_b), .pix_empty (pix_empty_b),
        .pix_req (pix_req_b), .red (red_b), .green (green_b), .blue (blue_b),
        .lcd_clk (lcd_clk_b), .lcd_disp (lcd_disp_b), .hsync (hsync_b), .vsync (vsync_b),
        .lcd_de (lcd_de_b), .frame_start (fs_b), .underflow_count (uf_b)
    );

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] bar_exp(input int unsigned idx);
        case (idx)
            0: return 24'hffffff;
            1: return 24'hffff00;
            2: return 24'h00ffff;
            3: return 24'h00ff00;
            4: return 24'hff00ff;
            5: return 24'hff0000;
            6: return 24'h0000ff;
            default: return 24'h000000;
        endcase
    endfunction

    // reference model state for the small instance
    logic        run_s = 1'b0;
    int unsigned e_s, m_pops, fifo_head, pops_frame, pops_last;
    logic [1:0]  m_lat;
    logic        m_disp, e_de, e_hs, e_vs, e_fs, e_req;
    logic [23:0] e_rgb;
    logic [15:0] m_uf;

    task automatic model_step();
        int unsigned slot, h, v;
        e_s++;
        e_fs  = 1'b0;
        e_req = 1'b0;
        if (e_s % (2 * CD) == 0) begin
            slot = e_s / (2 * CD) - 1;
            h = slot % HT;
            v = (slot / HT) % VT;
            if (h == 0 && v == 0) begin
                m_lat = mode_s; m_disp = 1'b1; e_fs = 1'b1;
                pops_last = pops_frame; pops_frame = 0;
            end
            e_de  = (h < HA) && (v < VA);
            e_hs  = !(h >= HA + HF && h < HA + HF + HS);
            e_vs  = !(v >= VA + VF && v < VA + VF + VS);
            e_rgb = '0;
            if (e_de) begin
                case (m_lat)
                    2'd0: if (pix_empty_s) begin
                              e_rgb = solid_s;
                              if (m_uf != 16'hffff) m_uf++;
                          end else begin
                              e_rgb = 24'(m_pops); m_pops++; e_req = 1'b1;
                          end
                    2'd1: e_rgb = solid_s;
                    2'd2: e_rgb = bar_exp((h * 8) / HA);
                    default: e_rgb = (((h >> 4) ^ (v >> 4)) & 1) != 0 ? 24'h0 : solid_s;
                endcase
            end
        end
        chk("lcd_clk", lcd_clk_s, (e_s / CD) % 2);
        chk("rgb", {red_s, green_s, blue_s}, e_rgb);
        chk("lcd_de", lcd_de_s, e_de);
        chk("hsync", hsync_s, e_hs);
        chk("vsync", vsync_s, e_vs);
        chk("frame_start", fs_s, e_fs);
        chk("lcd_disp", lcd_disp_s, m_disp);
        chk("pix_req", pix_req_s, e_req);
        chk("underflow_count", uf_s, m_uf);
        if (pix_req_s) begin
            fifo_head++;
            pix_data_s = 24'(fifo_head);
            pops_frame++;
        end
    endtask

    initial forever begin
        @(posedge CLOCK_50);
        #1;
        if (run_s) model_step();
    end

    task automatic release_small();
        @(negedge CLOCK_50);
        reset_s = 1'b0;
        e_s = 0; m_lat = 2'd1; m_disp = 1'b0; m_uf = '0;
        e_rgb = '0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_req = 1'b0;
        pops_frame = 0;
        run_s = 1'b1;
    endtask

    task automatic wait_edges(input int unsigned n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic chk_small_reset(input string tag);
        chk({tag, "_rgb"}, {red_s, green_s, blue_s}, 24'h0);
        chk({tag, "_hsync"}, hsync_s, 1'b1);
        chk({tag, "_vsync"}, vsync_s, 1'b1);
        chk({tag, "_de"}, lcd_de_s, 1'b0);
        chk({tag, "_disp"}, lcd_disp_s, 1'b0);
        chk({tag, "_req"}, pix_req_s, 1'b0);
        chk({tag, "_fs"}, fs_s, 1'b0);
        chk({tag, "_uf"}, uf_s, 16'h0);
        chk({tag, "_lcd_clk"}, lcd_clk_s, 1'b0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        int unsigned h;
        logic [23:0] rgb;
        logic        de;
    } vec_t;

    vec_t        tbl [10];
    int unsigned eb, target;
    logic [1:0]  cur_mode;

    initial begin
        tbl[0] = '{2'd2, 0,   24'hffffff, 1'b1};
        tbl[1] = '{2'd2, 59,  24'hffffff, 1'b1};
        tbl[2] = '{2'd2, 60,  24'hffff00, 1'b1};
        tbl[3] = '{2'd2, 419, 24'h0000ff, 1'b1};
        tbl[4] = '{2'd2, 420, 24'h000000, 1'b1};
        tbl[5] = '{2'd2, 480, 24'h000000, 1'b0};
        tbl[6] = '{2'd3, 0,   24'h123456, 1'b1};
        tbl[7] = '{2'd3, 15,  24'h123456, 1'b1};
        tbl[8] = '{2'd3, 16,  24'h000000, 1'b1};
        tbl[9] = '{2'd3, 32,  24'h123456, 1'b1};

        reset_s = 1'b1; reset_b = 1'b1;
        mode_s = 2'd1; solid_s = 24'hdea2d7; pix_empty_s = 1'b0; pix_data_s = '0;
        mode_b = 2'd2; solid_b = 24'h123456; pix_empty_b = 1'b1; pix_data_b = '0;
        fifo_head = 0; m_pops = 0; pops_last = 0;

        // reset held, then small raster in SOLID
        wait_edges(3);
        chk_small_reset("rst");
        chk("rst_b_hsync", hsync_b, 1'b1);
        release_small();
        wait_edges(4);
        chk("first_fs_edge4", fs_s, 1'b1);
        chk("disp_with_fs", lcd_disp_s, 1'b1);
        wait_edges(2 * HT * VT * 2 * CD - 4);

        // EXTERNAL requested mid-frame; never-empty FIFO
        wait_edges(150);
        mode_s = 2'd0;
        wait_edges(3 * HT * VT * 2 * CD);
        chk("pops_per_frame", pops_last, HA * VA);
        chk("uf_never_empty", uf_s, 16'h0);

        // randomized modes, colours and FIFO emptiness
        for (int i = 0; i < 2500; i++) begin
            @(posedge CLOCK_50);
            #2;
            pix_empty_s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) begin
                mode_s  = 2'($urandom_range(0, 3));
                solid_s = 24'($urandom);
            end
        end

        // async reset mid-frame, then three empty active pixels
        @(posedge CLOCK_50);
        #3;
        run_s = 1'b0;
        reset_s = 1'b1;
        #1;
        chk_small_reset("async");
        mode_s = 2'd0; pix_empty_s = 1'b0; solid_s = 24'h5a5a5a;
        release_small();
        wait_edges(4);
        pix_empty_s = 1'b1;
        wait_edges(12);
        pix_empty_s = 1'b0;
        wait_edges(314);
        chk("uf_three_empty", uf_s, 16'd3);
        chk("pops_three_empty", pops_frame, HA * VA - 3);

        // saturation from a preset count
        force dut_s.uf_cnt = 16'hfffd;
        m_uf = 16'hfffd;
        #1;
        release dut_s.uf_cnt;
        pix_empty_s = 1'b1;
        wait_edges(400);
        chk("uf_saturated", uf_s, 16'hffff);
        run_s = 1'b0;

        // full-size bars / checker table
        cur_mode = 2'd0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || tbl[i].mode != cur_mode) begin
                @(posedge CLOCK_50);
                #3;
                reset_b = 1'b1;
                #1;
                chk($sformatf("b_async_rgb%0d", i), {red_b, green_b, blue_b}, 24'h0);
                chk($sformatf("b_async_de%0d", i), lcd_de_b, 1'b0);
                chk($sformatf("b_async_fs%0d", i), fs_b, 1'b0);
                mode_b = tbl[i].mode;
                cur_mode = tbl[i].mode;
                @(negedge CLOCK_50);
                reset_b = 1'b0;
                eb = 0;
            end
            target = 4 * (tbl[i].h + 1);
            while (eb < target) begin
                @(posedge CLOCK_50);
                eb++;
            end
            #2;
            chk($sformatf("tbl%0d_rgb_h%0d", i, tbl[i].h), {red_b, green_b, blue_b}, tbl[i].rgb);
            chk($sformatf("tbl%0d_de_h%0d", i, tbl[i].h), lcd_de_b, tbl[i].de);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
